// File: rtl/program_counter_if.sv
// Instruction-fetch control and address bundle between the control FSM and the program counter.
// The control side drives the strobes and load value; the counter drives the address back.
interface program_counter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  w_en;
  logic                  complete;
  logic                  inc;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] instruction_address;

  modport master (
    output en,
    output w_en,
    output complete,
    output inc,
    output data_in,
    input  instruction_address
  );

  modport slave (
    input  en,
    input  w_en,
    input  complete,
    input  inc,
    input  data_in,
    output instruction_address
  );
endinterface

// File: rtl/program_counter.sv
// Instruction-address program counter: absolute load, +1 increment, freeze on program complete.
// Latency 1 cycle from sampled w_en/inc to address; no backpressure, en=0 or complete=1 simply hold.
module program_counter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_ADDR = 0
) (
  input logic             clk,
  input logic             rst_n,
  program_counter_if.slave pc_if
);

  localparam logic [ADDR_WIDTH-1:0] RESET_VAL = ADDR_WIDTH'(RESET_ADDR);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;

  // complete outranks both load and increment; load outranks increment
  always_comb begin
    addr_d = addr_q;
    if (pc_if.en && !pc_if.complete) begin
      if (pc_if.w_en) begin
        addr_d = pc_if.data_in[ADDR_WIDTH-1:0];
      end else if (pc_if.inc) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= RESET_VAL;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign pc_if.instruction_address = addr_q;

  // Upper load bits are architecturally ignored.
  generate
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_unused_upper
      logic unused_data_upper;
      assign unused_data_upper = ^pc_if.data_in[DATA_WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter with a queue-based scoreboard and a decoupled monitor.
module tb_program_counter;

  logic clk;
  logic rst_n;

  program_counter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) pc_if ();

  program_counter #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32),
    .RESET_ADDR(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc_if (pc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] exp_q[$];
  string      name_q[$];
  event       chk_ev;
  int         n_checks = 0;
  int         n_pass   = 0;

  // Monitor: whenever a sample is announced, drain and compare every queued expectation.
  initial begin
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        logic [5:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (pc_if.instruction_address === e) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got 0x%02h expected 0x%02h", nm, pc_if.instruction_address, e);
        end
      end
    end
  end

  task automatic expect_now(input logic [5:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    ->chk_ev;
  endtask

  // One rising edge with the current inputs, then sample 1ns later.
  task automatic step(input logic [5:0] e, input string nm);
    @(posedge clk);
    #1;
    expect_now(e, nm);
  endtask

  task automatic drive(input logic en, input logic w_en, input logic complete,
                       input logic inc, input logic [31:0] data);
    pc_if.en       = en;
    pc_if.w_en     = w_en;
    pc_if.complete = complete;
    pc_if.inc      = inc;
    pc_if.data_in  = data;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    expect_now(6'h00, "reset_async_initial");

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(6'h00, "reset_idle_hold");

    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5);
    step(6'h25, "load_a5a5a5a5");

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step(6'h26, "inc_first");
    step(6'h27, "inc_b2b_1");
    step(6'h28, "inc_b2b_2");
    step(6'h29, "inc_b2b_3");
    step(6'h2A, "inc_b2b_4");

    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010);
    step(6'h10, "load_beats_inc");

    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(6'h10, "en_low_holds_inc");

    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0003);
    step(6'h10, "complete_blocks_load");

    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step(6'h10, "complete_blocks_inc");

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step(6'h11, "resume_after_complete_1");
    step(6'h12, "resume_after_complete_2");

    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFC7);
    step(6'h07, "load_ignores_upper_bits");

    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_003F);
    step(6'h3F, "load_3f");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step(6'h00, "wrap_3f_to_00");
    step(6'h01, "after_wrap_01");
    step(6'h02, "count_02");
    step(6'h03, "count_03");

    // Mid-cycle reset while inc is still asserted.
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(6'h00, "async_reset_mid_count");
    step(6'h00, "reset_held_edge_1");
    step(6'h00, "reset_held_edge_2");
    #2;
    rst_n = 1'b1;
    step(6'h01, "first_inc_after_release");
    step(6'h02, "second_inc_after_release");

    // Load pulse that opens and closes between edges must not be seen.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0030);
    #1;
    pc_if.w_en = 1'b1;
    #1;
    pc_if.w_en = 1'b0;
    step(6'h02, "glitch_between_edges_ignored");

    #2;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
